// File: rtl/dsp_mac_sequencer.sv
// Sequencer that drives a single DSP48A1 slice as a multiply-accumulator.
// It streams operand beats into A/B with skewed OPMODE codes, then returns the drained P.
module dsp_mac_sequencer #(
    parameter int LATENCY = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [17:0]      s_a,
    input  logic [17:0]      s_b,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [47:0]      m_result,
    output logic [CNT_W-1:0] m_count,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [17:0]      dsp_d,
    output logic [47:0]      dsp_c,
    output logic             dsp_carryin,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_ce,
    output logic             dsp_rst,
    input  logic [47:0]      dsp_p
);
    localparam int DW = $clog2(LATENCY + 1) + 1;

    localparam logic [7:0] OP_CLEAR = 8'h00;
    localparam logic [7:0] OP_FIRST = 8'h01;
    localparam logic [7:0] OP_ACCUM = 8'h09;
    localparam logic [7:0] OP_HOLD  = 8'h08;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    state_t        state_reg, state_next;
    logic [DW-1:0] drain_cnt_reg;
    logic [7:0]    op_stage_reg;
    logic          accept;
    logic          drain_done;
    logic          handshake;
    logic [7:0]    op_code;

    assign dsp_d       = '0;
    assign dsp_c       = '0;
    assign dsp_carryin = 1'b0;

    assign s_ready    = !rst && ((state_reg == IDLE) || (state_reg == RUN));
    assign accept     = s_valid && s_ready;
    assign drain_done = (state_reg == DRAIN) && (drain_cnt_reg == DW'(LATENCY));
    assign handshake  = (state_reg == OUT) && m_ready;

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        op_code    = OP_CLEAR;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    op_code    = OP_FIRST;
                    state_next = s_last ? DRAIN : RUN;
                end
            end
            RUN: begin
                op_code = accept ? OP_ACCUM : OP_HOLD;
                if (accept && s_last) state_next = DRAIN;
            end
            DRAIN: begin
                op_code = OP_HOLD;
                if (drain_done) state_next = OUT;
            end
            OUT: begin
                if (m_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // OPMODE is staged one extra cycle so it meets the registered M product at the P register.
    always_ff @(posedge clk) begin
        if (rst) begin
            dsp_a        <= '0;
            dsp_b        <= '0;
            op_stage_reg <= OP_CLEAR;
            dsp_opmode   <= OP_CLEAR;
            dsp_ce       <= 1'b1;
            dsp_rst      <= 1'b1;
        end else begin
            dsp_a        <= accept ? s_a : 18'd0;
            dsp_b        <= accept ? s_b : 18'd0;
            op_stage_reg <= op_code;
            dsp_opmode   <= op_stage_reg;
            dsp_ce       <= 1'b1;
            dsp_rst      <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt_reg <= '0;
            m_valid       <= 1'b0;
            m_result      <= '0;
            m_count       <= '0;
        end else begin
            if (state_reg == DRAIN && !drain_done) drain_cnt_reg <= drain_cnt_reg + DW'(1);
            else                                   drain_cnt_reg <= '0;

            if (drain_done) begin
                m_result <= dsp_p;
                m_valid  <= 1'b1;
            end else if (handshake) begin
                m_valid  <= 1'b0;
            end

            if (handshake)                       m_count <= '0;
            else if (accept && (m_count != '1))  m_count <= m_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural DSP48A1 slice model closing the loop.
module tb_dsp_mac_sequencer;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             s_valid, s_ready, s_last;
    logic [17:0]      s_a, s_b;
    logic             m_valid, m_ready;
    logic [47:0]      m_result;
    logic [CNT_W-1:0] m_count;
    logic [17:0]      dsp_a, dsp_b, dsp_d;
    logic [47:0]      dsp_c, dsp_p;
    logic             dsp_carryin, dsp_ce, dsp_rst;
    logic [7:0]       dsp_opmode;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dsp_mac_sequencer #(.LATENCY(3), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result), .m_count(m_count),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d), .dsp_c(dsp_c),
        .dsp_carryin(dsp_carryin), .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce),
        .dsp_rst(dsp_rst), .dsp_p(dsp_p)
    );

    // Slice model: A1/B1 -> M -> P, OPMODE registered once; X=M when OPMODE[1:0]=01, Z=P when OPMODE[3:2]=10.
    logic signed [17:0] a1, b1;
    logic signed [47:0] m_prod;
    logic        [7:0]  op_r;
    logic        [47:0] p_r;
    assign dsp_p = p_r;

    always @(posedge clk) begin
        if (dsp_rst) begin
            a1 <= '0; b1 <= '0; m_prod <= '0; op_r <= '0; p_r <= '0;
        end else if (dsp_ce) begin
            a1     <= dsp_a;
            b1     <= dsp_b;
            m_prod <= a1 * b1;
            op_r   <= dsp_opmode;
            p_r    <= ((op_r[1:0] == 2'b01) ? m_prod : 48'd0) + ((op_r[3:2] == 2'b10) ? p_r : 48'd0);
        end
    end

    typedef struct {
        int               n;
        int               gap;
        int               bp;
        logic [4:0][17:0] a;
        logic [4:0][17:0] b;
        logic [47:0]      exp_result;
        int               exp_count;
    } vec_t;

    function automatic vec_t mk(int n, int gap, int bp, int a0, int b0, int a1v, int b1v,
                                int a2, int b2, longint exp_r, int exp_c);
        vec_t v;
        v.n = n; v.gap = gap; v.bp = bp;
        v.a = '0; v.b = '0;
        v.a[0] = 18'(a0); v.b[0] = 18'(b0);
        v.a[1] = 18'(a1v); v.b[1] = 18'(b1v);
        v.a[2] = 18'(a2); v.b[2] = 18'(b2);
        v.a[3] = 18'(1); v.b[3] = 18'(1);
        v.a[4] = 18'(1); v.b[4] = 18'(1);
        v.exp_result = 48'(exp_r);
        v.exp_count  = exp_c;
        return v;
    endfunction

    task automatic check(input string name, input longint actual, input longint expected);
        total++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int lat;
        logic [47:0] held;
        for (int i = 0; i < v.n; i++) begin
            @(negedge clk);
            s_valid = 1'b1; s_a = v.a[i]; s_b = v.b[i]; s_last = (i == v.n - 1);
            if (i < v.n - 1)
                for (int g = 0; g < v.gap; g++) begin
                    @(negedge clk);
                    s_valid = 1'b0; s_last = 1'b0;
                end
        end
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        check($sformatf("v%0d s_ready_drain", id), s_ready, 0);
        lat = 0;
        while (!m_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("v%0d latency", id), lat, 4);
        check($sformatf("v%0d result", id), m_result, v.exp_result);
        check($sformatf("v%0d count", id), m_count, v.exp_count);
        held = m_result;
        for (int k = 0; k < v.bp; k++) begin
            @(negedge clk);
            check($sformatf("v%0d bp%0d held", id, k), m_result, held);
            check($sformatf("v%0d bp%0d valid", id, k), m_valid, 1);
            check($sformatf("v%0d bp%0d s_ready", id, k), s_ready, 0);
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check($sformatf("v%0d post_valid", id), m_valid, 0);
        check($sformatf("v%0d post_ready", id), s_ready, 1);
        check($sformatf("v%0d post_count", id), m_count, 0);
        $display("vector %0d: result=%0d count=%0d latency=%0d", id, m_result, m_count, lat);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = mk(1, 0, 0, 3, 4, 0, 0, 0, 0, 12, 1);
        vecs[1] = mk(3, 0, 0, 1, 2, 3, 4, 5, 6, 44, 3);
        vecs[2] = mk(2, 3, 0, -2, 5, 7, 3, 0, 0, 11, 2);
        vecs[3] = mk(2, 0, 0, -2, 5, 7, 3, 0, 0, 11, 2);
        vecs[4] = mk(2, 0, 0, 131071, 131071, -131072, -131072, 0, 0, 64'h7FFFC0001, 2);
        vecs[5] = mk(1, 0, 5, -100, 50, 0, 0, 0, 0, -5000, 1);
        vecs[6] = mk(1, 0, 0, 2, 2, 0, 0, 0, 0, 4, 1);
        vecs[7] = mk(5, 1, 0, 1, 1, 1, 1, 1, 1, 5, 3);

        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_a = '0; s_b = '0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst s_ready", s_ready, 0);
        check("rst dsp_rst", dsp_rst, 1);
        check("rst m_valid", m_valid, 0);
        check("rst m_result", m_result, 0);
        check("rst m_count", m_count, 0);
        check("rst opmode", dsp_opmode, 0);
        check("rst dsp_ce", dsp_ce, 1);
        check("rst dsp_a", dsp_a, 0);
        rst = 1'b0;
        #1;
        check("rst release s_ready", s_ready, 1);
        repeat (2) @(negedge clk);
        check("idle dsp_rst", dsp_rst, 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Abandon a 4-beat vector after two beats with a one-cycle reset.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            s_valid = 1'b1; s_a = 18'(9); s_b = 18'(9); s_last = 1'b0;
        end
        @(negedge clk);
        s_valid = 1'b0; rst = 1'b1;
        #1;
        check("midrst s_ready_in_rst", s_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst dsp_rst", dsp_rst, 1);
        check("midrst m_count", m_count, 0);
        check("midrst opmode", dsp_opmode, 0);
        check("midrst dsp_a", dsp_a, 0);
        check("midrst s_ready", s_ready, 1);
        @(negedge clk);
        check("midrst dsp_rst_drop", dsp_rst, 0);
        repeat (6) @(negedge clk);
        check("midrst no_valid", m_valid, 0);
        $display("vector mid-reset: abandoned after 2 beats, m_valid=%0d", m_valid);

        run_vec(mk(1, 0, 0, 6, 7, 0, 0, 0, 0, 42, 1), 8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule
